rv32_core: RTL and testbench

- Single-cycle RV32I-subset processor.
- Contains its own instruction ROM, data RAM and a 32x32 register file.
- Retires one instruction per rising clock edge.
- Exposes all 32 architectural registers as flat outputs for bench observation; top-level compute block with no external bus.

---
 rtl/rv32_pkg.sv | 76 +++++++
 rtl/rv32_alu.sv | 43 ++++
 rtl/rv32_core.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_rv32_core.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: opcode/funct constants, decode enums and the
// immediate generator shared by the rv32_core slice.
package rv32_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
        ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_SLT, ALU_SLTU, ALU_MUL
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_t;

    typedef enum logic [1:0] {
        WB_ALU, WB_MEM, WB_PC4
    } wb_sel_t;

    typedef enum logic [1:0] {
        A_RS1, A_PC, A_ZERO
    } a_sel_t;

    function automatic logic [31:0] imm_gen(
        input logic [31:0] i,
        input imm_fmt_t    f
    );
        logic [31:0] r;
        unique case (f)
            IMM_S: r = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B: r = {{19{i[31]}}, i[31], i[7],
                        i[30:25], i[11:8], 1'b0};
            IMM_U: r = {i[31:12], 12'b0};
            IMM_J: r = {{11{i[31]}}, i[31], i[19:12],
                        i[20], i[30:21], 1'b0};
            default: r = {{20{i[31]}}, i[31:20]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rv32_alu.sv
// rv32_alu: combinational ALU with compare flags taken
// straight from the operands. mul exists only with RV_MUL_EN.
module rv32_alu
    import rv32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     op,
    output logic [31:0] y,
    output logic        zero,
    output logic        lt,
    output logic        ltu
);

    logic [4:0] sh;

    assign sh   = b[4:0];
    assign zero = (a == b);
    assign lt   = $signed(a) < $signed(b);
    assign ltu  = a < b;

    // result select by operation
    always_comb begin
        y = '0;
        unique case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLL:  y = a << sh;
            ALU_SRL:  y = a >> sh;
            ALU_SRA:  y = $signed(a) >>> sh;
            ALU_SLT:  y = {31'b0, lt};
            ALU_SLTU: y = {31'b0, ltu};
`ifdef RV_MUL_EN
            ALU_MUL:  y = a * b;
`endif
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/rv32_core.sv
// rv32_core: single-cycle RV32I subset with internal ROM/RAM.
// Optional RV_MUL_EN adds the mul instruction.
module rv32_core
    import rv32_pkg::*;
#(
    parameter int    IMEM_DEPTH = 256,
    parameter int    DMEM_DEPTH = 256,
    parameter string IMEM_FILE  = "program.hex"
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] reg1,  output logic [31:0] reg2,
    output logic [31:0] reg3,  output logic [31:0] reg4,
    output logic [31:0] reg5,  output logic [31:0] reg6,
    output logic [31:0] reg7,  output logic [31:0] reg8,
    output logic [31:0] reg9,  output logic [31:0] reg10,
    output logic [31:0] reg11, output logic [31:0] reg12,
    output logic [31:0] reg13, output logic [31:0] reg14,
    output logic [31:0] reg15, output logic [31:0] reg16,
    output logic [31:0] reg17, output logic [31:0] reg18,
    output logic [31:0] reg19, output logic [31:0] reg20,
    output logic [31:0] reg21, output logic [31:0] reg22,
    output logic [31:0] reg23, output logic [31:0] reg24,
    output logic [31:0] reg25, output logic [31:0] reg26,
    output logic [31:0] reg27, output logic [31:0] reg28,
    output logic [31:0] reg29, output logic [31:0] reg30,
    output logic [31:0] reg31, output logic [31:0] reg32
);

    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] dmem [DMEM_DEPTH];
    logic [31:0] rf   [32];
    logic [31:0] pc;

    logic [31:0] insn;
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1v;
    logic [31:0] rs2v;
    logic [31:0] imm;

    imm_fmt_t    fmt;
    alu_op_t     op;
    a_sel_t      asel;
    wb_sel_t     wb;
    logic        bimm;
    logic        we;
    logic        st;
    logic        br;
    logic        jmp;
    logic        jr;
    logic        taken;

    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        zero;
    logic        lt;
    logic        ltu;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [31:0] pc4;
    logic [31:0] pc_next;

    // ROM defaults to nop and RAM to zero
    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = NOP_INSN;
        for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] = '0;
    end

    assign insn = imem[pc[IW+1:2]];
    assign opc  = insn[6:0];
    assign rd   = insn[11:7];
    assign f3   = insn[14:12];
    assign rs1  = insn[19:15];
    assign rs2  = insn[24:20];
    assign f7   = insn[31:25];
    assign rs1v = rf[rs1];
    assign rs2v = rf[rs2];
    assign imm  = imm_gen(insn, fmt);

    // decode; anything not matched stays a nop
    always_comb begin
        fmt  = IMM_I;
        op   = ALU_ADD;
        asel = A_RS1;
        wb   = WB_ALU;
        bimm = 1'b0;
        we   = 1'b0;
        st   = 1'b0;
        br   = 1'b0;
        jmp  = 1'b0;
        jr   = 1'b0;
        unique case (opc)
            OP_LUI: begin
                fmt  = IMM_U;
                asel = A_ZERO;
                bimm = 1'b1;
                we   = 1'b1;
            end
            OP_AUIPC: begin
                fmt  = IMM_U;
                asel = A_PC;
                bimm = 1'b1;
                we   = 1'b1;
            end
            OP_JAL: begin
                fmt = IMM_J;
                wb  = WB_PC4;
                we  = 1'b1;
                jmp = 1'b1;
            end
            OP_JALR: begin
                if (f3 == F3_JALR) begin
                    bimm = 1'b1;
                    wb   = WB_PC4;
                    we   = 1'b1;
                    jr   = 1'b1;
                end
            end
            OP_BRANCH: begin
                fmt = IMM_B;
                br  = (f3 != 3'b010) && (f3 != 3'b011);
            end
            OP_LOAD: begin
                if (f3 == F3_LW) begin
                    bimm = 1'b1;
                    wb   = WB_MEM;
                    we   = 1'b1;
                end
            end
            OP_STORE: begin
                if (f3 == F3_SW) begin
                    fmt  = IMM_S;
                    bimm = 1'b1;
                    st   = 1'b1;
                end
            end
            OP_IMM: begin
                bimm = 1'b1;
                unique case (f3)
                    F3_ADD:  begin op = ALU_ADD;  we = 1'b1; end
                    F3_SLT:  begin op = ALU_SLT;  we = 1'b1; end
                    F3_SLTU: begin op = ALU_SLTU; we = 1'b1; end
                    F3_XOR:  begin op = ALU_XOR;  we = 1'b1; end
                    F3_OR:   begin op = ALU_OR;   we = 1'b1; end
                    F3_AND:  begin op = ALU_AND;  we = 1'b1; end
                    F3_SLL: begin
                        if (f7 == F7_BASE) begin
                            op = ALU_SLL;
                            we = 1'b1;
                        end
                    end
                    default: begin
                        if (f7 == F7_BASE) begin
                            op = ALU_SRL;
                            we = 1'b1;
                        end else if (f7 == F7_ALT) begin
                            op = ALU_SRA;
                            we = 1'b1;
                        end
                    end
                endcase
            end
            OP_REG: begin
                if (f7 == F7_BASE) begin
                    we = 1'b1;
                    unique case (f3)
                        F3_ADD:  op = ALU_ADD;
                        F3_SLL:  op = ALU_SLL;
                        F3_SLT:  op = ALU_SLT;
                        F3_SLTU: op = ALU_SLTU;
                        F3_XOR:  op = ALU_XOR;
                        F3_SR:   op = ALU_SRL;
                        F3_OR:   op = ALU_OR;
                        default: op = ALU_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == F3_ADD) begin
                    op = ALU_SUB;
                    we = 1'b1;
                end else if (f7 == F7_ALT && f3 == F3_SR) begin
                    op = ALU_SRA;
                    we = 1'b1;
                end
`ifdef RV_MUL_EN
                else if (f7 == F7_MUL && f3 == F3_ADD) begin
                    op = ALU_MUL;
                    we = 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    // operand select
    always_comb begin
        unique case (asel)
            A_PC:    a = pc;
            A_ZERO:  a = '0;
            default: a = rs1v;
        endcase
        b = bimm ? imm : rs2v;
    end

    rv32_alu u_alu (
        .a    (a),
        .b    (b),
        .op   (op),
        .y    (y),
        .zero (zero),
        .lt   (lt),
        .ltu  (ltu)
    );

    // branch resolution from the ALU compare flags
    always_comb begin
        taken = 1'b0;
        if (br) begin
            unique case (f3)
                F3_BEQ:  taken = zero;
                F3_BNE:  taken = !zero;
                F3_BLT:  taken = lt;
                F3_BGE:  taken = !lt;
                F3_BLTU: taken = ltu;
                F3_BGEU: taken = !ltu;
                default: taken = 1'b0;
            endcase
        end
    end

    assign rdata = dmem[y[DW+1:2]];
    assign pc4   = pc + 32'd4;

    // writeback and next-PC select
    always_comb begin
        unique case (wb)
            WB_MEM:  wdata = rdata;
            WB_PC4:  wdata = pc4;
            default: wdata = y;
        endcase
        if (jr)
            pc_next = {y[31:1], 1'b0};
        else if (jmp || taken)
            pc_next = pc + imm;
        else
            pc_next = pc4;
    end

    // architectural state; rf[0] is never written so x0 stays zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            pc <= pc_next;
            if (we && rd != 5'd0) rf[rd] <= wdata;
        end
    end

    // data RAM write port, not reset
    always_ff @(posedge clock) begin
        if (reset && st) dmem[y[DW+1:2]] <= rs2v;
    end

    assign reg1  = rf[0];  assign reg2  = rf[1];
    assign reg3  = rf[2];  assign reg4  = rf[3];
    assign reg5  = rf[4];  assign reg6  = rf[5];
    assign reg7  = rf[6];  assign reg8  = rf[7];
    assign reg9  = rf[8];  assign reg10 = rf[9];
    assign reg11 = rf[10]; assign reg12 = rf[11];
    assign reg13 = rf[12]; assign reg14 = rf[13];
    assign reg15 = rf[14]; assign reg16 = rf[15];
    assign reg17 = rf[16]; assign reg18 = rf[17];
    assign reg19 = rf[18]; assign reg20 = rf[19];
    assign reg21 = rf[20]; assign reg22 = rf[21];
    assign reg23 = rf[22]; assign reg24 = rf[23];
    assign reg25 = rf[24]; assign reg26 = rf[25];
    assign reg27 = rf[26]; assign reg28 = rf[27];
    assign reg29 = rf[28]; assign reg30 = rf[29];
    assign reg31 = rf[30]; assign reg32 = rf[31];

endmodule

// File: tb/tb_rv32_core.sv
// tb_rv32_core: directed programs loaded into the core ROM,
// register outputs checked against hand-computed values.
module tb_rv32_core;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] OPI = 32'h13;
    localparam logic [31:0] OPR = 32'h33;

    logic        clock;
    logic        reset;
    logic [31:0] rv [32];
    logic [31:0] prog [16];
    int          plen;
    int          n_cmp;
    int          n_bad;

    rv32_core #(
        .IMEM_DEPTH (256),
        .DMEM_DEPTH (256),
        .IMEM_FILE  ("")
    ) dut (
        .clock (clock),
        .reset (reset),
        .reg1  (rv[0]),  .reg2  (rv[1]),
        .reg3  (rv[2]),  .reg4  (rv[3]),
        .reg5  (rv[4]),  .reg6  (rv[5]),
        .reg7  (rv[6]),  .reg8  (rv[7]),
        .reg9  (rv[8]),  .reg10 (rv[9]),
        .reg11 (rv[10]), .reg12 (rv[11]),
        .reg13 (rv[12]), .reg14 (rv[13]),
        .reg15 (rv[14]), .reg16 (rv[15]),
        .reg17 (rv[16]), .reg18 (rv[17]),
        .reg19 (rv[18]), .reg20 (rv[19]),
        .reg21 (rv[20]), .reg22 (rv[21]),
        .reg23 (rv[22]), .reg24 (rv[23]),
        .reg25 (rv[24]), .reg26 (rv[25]),
        .reg27 (rv[26]), .reg28 (rv[27]),
        .reg29 (rv[28]), .reg30 (rv[29]),
        .reg31 (rv[30]), .reg32 (rv[31])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(
        input logic [31:0] imm, input logic [31:0] r1,
        input logic [31:0] f3,  input logic [31:0] rd,
        input logic [31:0] opc
    );
        return {imm[11:0], r1[4:0], f3[2:0], rd[4:0], opc[6:0]};
    endfunction

    function automatic logic [31:0] enc_r(
        input logic [31:0] f7, input logic [31:0] r2,
        input logic [31:0] r1, input logic [31:0] f3,
        input logic [31:0] rd
    );
        return {f7[6:0], r2[4:0], r1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(
        input logic [31:0] imm, input logic [31:0] r2,
        input logic [31:0] r1
    );
        return {imm[11:5], r2[4:0], r1[4:0], 3'b010,
                imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(
        input logic [31:0] imm, input logic [31:0] r2,
        input logic [31:0] r1,  input logic [31:0] f3
    );
        return {imm[12], imm[10:5], r2[4:0], r1[4:0], f3[2:0],
                imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(
        input logic [31:0] imm, input logic [31:0] rd
    );
        return {imm[20], imm[10:1], imm[11], imm[19:12],
                rd[4:0], 7'h6f};
    endfunction

    function automatic logic [31:0] enc_u(
        input logic [31:0] imm, input logic [31:0] rd,
        input logic [31:0] opc
    );
        return {imm[19:0], rd[4:0], opc[6:0]};
    endfunction

    // hold reset, rewrite the ROM with prog[0..plen-1], release
    task automatic start();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 256; i++) dut.imem[i] = NOP;
        for (int i = 0; i < plen; i++) dut.imem[i] = prog[i];
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic all_zero(input string tag);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s reg%0d", tag, i + 1), rv[i], 32'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        plen  = 0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        all_zero("rst");

        // x0 stays zero
        prog[0] = enc_i(5, 0, 0, 0, OPI);
        plen = 1;
        start();
        step(1);
        check("x0", rv[0], 32'h0);

        // ALU sequence
        prog[0] = enc_i(5, 0, 0, 1, OPI);
        prog[1] = enc_i(-3, 0, 0, 2, OPI);
        prog[2] = enc_r(0, 2, 1, 0, 3);
        prog[3] = enc_r(32, 1, 2, 0, 4);
        prog[4] = enc_r(32, 1, 4, 5, 5);
        plen = 5;
        start();
        step(5);
        check("alu x1", rv[1], 32'h0000_0005);
        check("alu x2", rv[2], 32'hFFFF_FFFD);
        check("alu x3", rv[3], 32'h0000_0002);
        check("alu x4", rv[4], 32'hFFFF_FFF8);
        check("alu x5", rv[5], 32'hFFFF_FFFF);

        // compares, shifts, illegal word, mul
        prog[0] = enc_i(-1, 0, 0, 1, OPI);
        prog[1] = enc_r(0, 1, 0, 3, 2);
        prog[2] = enc_r(0, 0, 1, 2, 3);
        prog[3] = 32'h0000_0000;
        prog[4] = enc_i(28, 1, 5, 4, OPI);
        prog[5] = enc_i(32'h0F0, 1, 4, 5, OPI);
        prog[6] = enc_r(1, 1, 1, 0, 6);
        plen = 7;
        start();
        step(7);
        check("sltu", rv[2], 32'h1);
        check("slt", rv[3], 32'h1);
        check("srli", rv[4], 32'h0000_000F);
        check("xori", rv[5], 32'hFFFF_FF0F);
`ifdef RV_MUL_EN
        check("mul", rv[6], 32'h1);
`else
        check("mul nop", rv[6], 32'h0);
`endif

        // store then load same word
        prog[0] = enc_i(32'h55, 0, 0, 1, OPI);
        prog[1] = enc_s(8, 1, 0);
        prog[2] = enc_i(8, 0, 2, 6, 32'h03);
        plen = 3;
        start();
        step(3);
        check("lw", rv[6], 32'h0000_0055);

        // beq taken, bne not taken
        for (int k = 0; k < 2; k++) begin
            prog[0] = enc_i(1, 0, 0, 6, OPI);
            prog[1] = enc_b(8, 6, 6, k);
            prog[2] = enc_i(9, 0, 0, 7, OPI);
            prog[3] = enc_i(7, 0, 0, 8, OPI);
            plen = 4;
            start();
            step(4);
            check($sformatf("br%0d x7", k), rv[7],
                  (k == 0) ? 32'h0 : 32'h9);
            check($sformatf("br%0d x8", k), rv[8], 32'h7);
        end

        // bltu and blt taken on -1
        prog[0] = enc_i(-1, 0, 0, 1, OPI);
        prog[1] = enc_b(8, 1, 0, 6);
        prog[2] = enc_i(1, 0, 0, 2, OPI);
        prog[3] = enc_b(8, 0, 1, 4);
        prog[4] = enc_i(1, 0, 0, 3, OPI);
        prog[5] = enc_i(4, 0, 0, 4, OPI);
        plen = 6;
        start();
        step(4);
        check("bltu", rv[2], 32'h0);
        check("blt", rv[3], 32'h0);
        check("br tgt", rv[4], 32'h4);

        // auipc, jal, lui, jalr
        prog[0] = enc_u(1, 11, 32'h17);
        prog[1] = NOP;
        prog[2] = NOP;
        prog[3] = NOP;
        prog[4] = enc_j(8, 1);
        prog[5] = enc_i(1, 10, 0, 10, OPI);
        prog[6] = enc_u(32'h12345, 9, 32'h37);
        prog[7] = enc_i(0, 1, 0, 0, 32'h67);
        plen = 8;
        start();
        step(6);
        check("auipc", rv[11], 32'h0000_1000);
        check("jal link", rv[1], 32'h0000_0014);
        check("jal skip", rv[10], 32'h0);
        check("lui", rv[9], 32'h1234_5000);
        step(2);
        check("jalr", rv[10], 32'h1);

        // reset mid-run between edges
        for (int i = 0; i < 5; i++)
            prog[i] = enc_i(i + 1, 0, 0, i + 1, OPI);
        plen = 5;
        start();
        step(5);
        check("pre x5", rv[5], 32'h5);
        #1;
        reset = 1'b0;
        #1;
        all_zero("mid");
        @(negedge clock);
        reset = 1'b1;
        step(1);
        check("restart x1", rv[1], 32'h1);
        check("restart x2", rv[2], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
